// File: rtl/collision_scan.sv
// Sequential point-vs-object-table region test: scans NUM_OBJ entries, one per cycle,
// against a latched check point and reports any-hit, lowest hit index and hit count.
module collision_scan #(
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int NUM_OBJ = 8,
    parameter int IDXW    = $clog2(NUM_OBJ)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [XW-1:0]   wr_x,
    input  logic [YW-1:0]   wr_y,
    input  logic [XW-1:0]   wr_radius,
    input  logic            wr_valid,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XW-1:0]   check_x,
    input  logic [YW-1:0]   check_y,
    input  logic            mode,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_hit,
    output logic [IDXW-1:0] rsp_idx,
    output logic [IDXW:0]   rsp_count
);

    localparam int SW = ((XW > YW) ? XW : YW) + 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NUM_OBJ - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FLUSH, ST_DONE} state_t;

    // Distances are magnitudes of unsigned differences; the diamond sum gets one
    // extra bit so radius 1023 against a far corner cannot alias into a hit.
    function automatic logic obj_hit(
        input logic [XW-1:0] px, input logic [YW-1:0] py, input logic md,
        input logic [XW-1:0] ox, input logic [YW-1:0] oy,
        input logic [XW-1:0] r,  input logic v
    );
        logic [XW-1:0] dx;
        logic [YW-1:0] dy;
        logic [SW-1:0] dxe, dye, re;
        dx  = (px > ox) ? (px - ox) : (ox - px);
        dy  = (py > oy) ? (py - oy) : (oy - py);
        dxe = SW'(dx);
        dye = SW'(dy);
        re  = SW'(r);
        if (!v)
            return 1'b0;
        if (md)
            return re > (dxe + dye);
        return (re > dxe) && (re > dye);
    endfunction

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [XW-1:0]     pt_x_q, pt_x_d;
    logic [YW-1:0]     pt_y_q, pt_y_d;
    logic              mode_q, mode_d;
    logic              vld_p1_q, vld_p1_d;
    logic              hit_p1_q, hit_p1_d;
    logic [IDXW-1:0]   idx_p1_q, idx_p1_d;
    logic              hit_q, hit_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW:0]     count_q, count_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              req_ready_q, req_ready_d;

    logic [XW-1:0]     obj_x_q [NUM_OBJ];
    logic [XW-1:0]     obj_x_d [NUM_OBJ];
    logic [YW-1:0]     obj_y_q [NUM_OBJ];
    logic [YW-1:0]     obj_y_d [NUM_OBJ];
    logic [XW-1:0]     obj_r_q [NUM_OBJ];
    logic [XW-1:0]     obj_r_d [NUM_OBJ];
    logic              obj_v_q [NUM_OBJ];
    logic              obj_v_d [NUM_OBJ];

    always_comb begin
        obj_x_d = obj_x_q;
        obj_y_d = obj_y_q;
        obj_r_d = obj_r_q;
        obj_v_d = obj_v_q;
        if (wr_en && (32'(wr_idx) < NUM_OBJ)) begin
            obj_x_d[wr_idx] = wr_x;
            obj_y_d[wr_idx] = wr_y;
            obj_r_d[wr_idx] = wr_radius;
            obj_v_d[wr_idx] = wr_valid;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        pt_x_d   = pt_x_q;
        pt_y_d   = pt_y_q;
        mode_d   = mode_q;
        hit_d    = hit_q;
        idx_d    = idx_q;
        count_d  = count_q;
        vld_p1_d = 1'b0;
        idx_p1_d = ptr_q;
        hit_p1_d = obj_hit(pt_x_q, pt_y_q, mode_q, obj_x_q[ptr_q], obj_y_q[ptr_q],
                           obj_r_q[ptr_q], obj_v_q[ptr_q]);

        // Stage p1 -> accumulate: only the first hit claims the index
        if (vld_p1_q && hit_p1_q) begin
            if (!hit_q)
                idx_d = idx_p1_q;
            hit_d   = 1'b1;
            count_d = count_q + (IDXW+1)'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_SCAN;
                    pt_x_d  = check_x;
                    pt_y_d  = check_y;
                    mode_d  = mode;
                    ptr_d   = '0;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    count_d = '0;
                end
            end
            ST_SCAN: begin
                vld_p1_d = 1'b1;
                if (ptr_q == LAST)
                    state_d = ST_FLUSH;
                else
                    ptr_d = ptr_q + IDXW'(1);
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        rsp_valid_d = (state_d == ST_DONE);
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            vld_p1_q    <= 1'b0;
            hit_q       <= 1'b0;
            idx_q       <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            for (int i = 0; i < NUM_OBJ; i++)
                obj_v_q[i] <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            vld_p1_q    <= vld_p1_d;
            hit_q       <= hit_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            obj_v_q     <= obj_v_d;
        end
    end

    always_ff @(posedge Clk) begin
        pt_x_q   <= pt_x_d;
        pt_y_q   <= pt_y_d;
        mode_q   <= mode_d;
        hit_p1_q <= hit_p1_d;
        idx_p1_q <= idx_p1_d;
        obj_x_q  <= obj_x_d;
        obj_y_q  <= obj_y_d;
        obj_r_q  <= obj_r_d;
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = hit_q;
    assign rsp_idx   = idx_q;
    assign rsp_count = count_q;

endmodule

// File: tb/tb_collision_scan.sv
// Bench for collision_scan: directed scenarios plus random tables checked against
// a plain-arithmetic model of the square/diamond region rules.
module tb_collision_scan;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_idx = '0;
    logic [9:0] wr_x = '0;
    logic [8:0] wr_y = '0;
    logic [9:0] wr_radius = '0;
    logic       wr_valid = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [9:0] check_x = '0;
    logic [8:0] check_y = '0;
    logic       mode = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_hit;
    logic [2:0] rsp_idx;
    logic [3:0] rsp_count;

    int total = 0;
    int bad = 0;

    int m_x [8];
    int m_y [8];
    int m_r [8];
    bit m_v [8];

    collision_scan #(.XW(10), .YW(9), .NUM_OBJ(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_radius(wr_radius), .wr_valid(wr_valid),
        .req_valid(req_valid), .req_ready(req_ready),
        .check_x(check_x), .check_y(check_y), .mode(mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_idx(rsp_idx), .rsp_count(rsp_count)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input int k, input int x, input int y, input int r, input bit v);
        wr_en = 1'b1; wr_idx = 3'(k); wr_x = 10'(x); wr_y = 9'(y);
        wr_radius = 10'(r); wr_valid = v;
        tick;
        wr_en = 1'b0;
        m_x[k] = x; m_y[k] = y; m_r[k] = r; m_v[k] = v;
    endtask

    task automatic clear_all;
        for (int k = 0; k < 8; k++) wr(k, 0, 0, 0, 1'b0);
    endtask

    task automatic model(input int x, input int y, input int md,
                         output int h, output int i, output int c);
        int dx, dy;
        bit in_reg;
        h = 0; i = 0; c = 0;
        for (int k = 0; k < 8; k++) begin
            dx = (x > m_x[k]) ? x - m_x[k] : m_x[k] - x;
            dy = (y > m_y[k]) ? y - m_y[k] : m_y[k] - y;
            in_reg = (md != 0) ? (m_r[k] > dx + dy) : (m_r[k] > dx && m_r[k] > dy);
            if (m_v[k] && in_reg) begin
                if (h == 0) i = k;
                h = 1;
                c++;
            end
        end
    endtask

    task automatic do_req(input int x, input int y, input int md,
                          output int lat, output int h, output int i, output int c);
        req_valid = 1'b1; check_x = 10'(x); check_y = 9'(y); mode = md[0];
        tick;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick;
            lat++;
        end
        if (!rsp_valid) lat = -1;
        h = int'(rsp_hit); i = int'(rsp_idx); c = int'(rsp_count);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        int lat, h, i, c;
        Reset = 1'b1;
        tick; tick;
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) m_v[k] = 1'b0;
        tick;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if ({rsp_valid, rsp_hit, rsp_idx, rsp_count} !== 9'd0) begin bad++;
            $display("FAIL reset_outputs got=%b%b %0d %0d exp=0", rsp_valid, rsp_hit, rsp_idx, rsp_count); end
        do_req(5, 5, 0, lat, h, i, c);
        total++; if (lat !== 9) begin bad++; $display("FAIL empty_latency got=%0d exp=9", lat); end
        total++; if (h !== 0 || i !== 0 || c !== 0) begin bad++;
            $display("FAIL empty_scan got=%0d/%0d/%0d exp=0/0/0", h, i, c); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rsp got=%b exp=1", req_ready); end
    endtask

    task automatic test_single;
        int lat, h, i, c;
        wr(2, 100, 50, 10, 1'b1);
        do_req(109, 41, 0, lat, h, i, c);
        total++; if (h !== 1 || i !== 2 || c !== 1) begin bad++;
            $display("FAIL single_hit got=%0d/%0d/%0d exp=1/2/1", h, i, c); end
        do_req(110, 50, 0, lat, h, i, c);
        total++; if (h !== 0 || i !== 0 || c !== 0) begin bad++;
            $display("FAIL single_edge_miss got=%0d/%0d/%0d exp=0/0/0", h, i, c); end
    endtask

    task automatic test_cluster;
        int lat, h, i, c;
        wr(1, 20, 20, 5, 1'b1);
        wr(4, 20, 20, 5, 1'b1);
        wr(6, 20, 20, 5, 1'b1);
        do_req(22, 18, 0, lat, h, i, c);
        total++; if (h !== 1 || i !== 1 || c !== 3) begin bad++;
            $display("FAIL cluster_square got=%0d/%0d/%0d exp=1/1/3", h, i, c); end
        do_req(22, 18, 1, lat, h, i, c);
        total++; if (h !== 1 || i !== 1 || c !== 3) begin bad++;
            $display("FAIL cluster_diamond got=%0d/%0d/%0d exp=1/1/3", h, i, c); end
        do_req(23, 22, 1, lat, h, i, c);
        total++; if (h !== 0 || i !== 0 || c !== 0) begin bad++;
            $display("FAIL cluster_diamond_edge got=%0d/%0d/%0d exp=0/0/0", h, i, c); end
        do_req(23, 22, 0, lat, h, i, c);
        total++; if (h !== 1 || i !== 1 || c !== 3) begin bad++;
            $display("FAIL cluster_square_far got=%0d/%0d/%0d exp=1/1/3", h, i, c); end
    endtask

    task automatic test_boundary;
        int lat, h, i, c;
        clear_all;
        wr(0, 0, 0, 1023, 1'b1);
        do_req(1023, 511, 0, lat, h, i, c);
        total++; if (h !== 0 || c !== 0) begin bad++;
            $display("FAIL max_corner got=%0d/%0d exp=0/0", h, c); end
        do_req(1022, 0, 0, lat, h, i, c);
        total++; if (h !== 1 || i !== 0 || c !== 1) begin bad++;
            $display("FAIL max_inside got=%0d/%0d/%0d exp=1/0/1", h, i, c); end
        do_req(1022, 0, 1, lat, h, i, c);
        total++; if (h !== 1 || c !== 1) begin bad++;
            $display("FAIL max_diamond_inside got=%0d/%0d exp=1/1", h, c); end
        do_req(600, 500, 1, lat, h, i, c);
        total++; if (h !== 0 || c !== 0) begin bad++;
            $display("FAIL diamond_no_wrap got=%0d/%0d exp=0/0", h, c); end
        wr(5, 0, 0, 0, 1'b1);
        do_req(0, 0, 0, lat, h, i, c);
        total++; if (h !== 1 || i !== 0 || c !== 1) begin bad++;
            $display("FAIL radius_zero got=%0d/%0d/%0d exp=1/0/1", h, i, c); end
        wr(7, 0, 0, 50, 1'b0);
        do_req(1, 1, 0, lat, h, i, c);
        total++; if (c !== 1) begin bad++; $display("FAIL invalid_entry got=%0d exp=1", c); end
    endtask

    task automatic test_hold;
        int n, eh, ei, ec;
        clear_all;
        wr(3, 200, 100, 30, 1'b1);
        wr(5, 210, 110, 30, 1'b1);
        model(205, 105, 1, eh, ei, ec);
        req_valid = 1'b1; check_x = 10'd205; check_y = 9'd105; mode = 1'b1;
        tick;
        n = 0;
        while (!rsp_valid && n < 40) begin tick; n++; end
        total++; if (n !== 9) begin bad++; $display("FAIL hold_latency got=%0d exp=9", n); end
        for (int k = 0; k < 5; k++) begin
            tick;
            total++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin bad++;
                $display("FAIL hold_handshake cyc=%0d got=%b%b exp=10", k, rsp_valid, req_ready); end
            total++; if (int'(rsp_hit) !== eh || int'(rsp_idx) !== ei || int'(rsp_count) !== ec) begin bad++;
                $display("FAIL hold_stable cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         k, rsp_hit, rsp_idx, rsp_count, eh, ei, ec); end
        end
        rsp_ready = 1'b1; req_valid = 1'b0;
        tick;
        rsp_ready = 1'b0;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++;
            $display("FAIL hold_release got=%b%b exp=10", req_ready, rsp_valid); end
        tick; tick;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL no_stale_accept got=%b exp=1", req_ready); end
    endtask

    task automatic test_reset_mid;
        int lat, h, i, c;
        wr(0, 20, 20, 9, 1'b1);
        wr(6, 20, 20, 9, 1'b1);
        req_valid = 1'b1; check_x = 10'd20; check_y = 9'd20; mode = 1'b0;
        tick;
        req_valid = 1'b0;
        tick; tick;
        Reset = 1'b1;
        #1;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++;
            $display("FAIL reset_mid_abort got=%b%b exp=01", rsp_valid, req_ready); end
        tick;
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) m_v[k] = 1'b0;
        tick; tick;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_no_rsp got=%b exp=0", rsp_valid); end
        do_req(20, 20, 0, lat, h, i, c);
        total++; if (h !== 0 || c !== 0) begin bad++;
            $display("FAIL reset_mid_cleared got=%0d/%0d exp=0/0", h, c); end
    endtask

    task automatic test_random;
        int lat, h, i, c, eh, ei, ec, nw, px, py, md;
        for (int it = 0; it < 40; it++) begin
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++)
                wr($urandom_range(0, 7), $urandom_range(0, 80), $urandom_range(0, 80),
                   $urandom_range(0, 25), $urandom_range(0, 3) != 0);
            px = $urandom_range(0, 80);
            py = $urandom_range(0, 80);
            md = $urandom_range(0, 1);
            model(px, py, md, eh, ei, ec);
            do_req(px, py, md, lat, h, i, c);
            total++; if (lat !== 9 || h !== eh || i !== ei || c !== ec) begin bad++;
                $display("FAIL random it=%0d pt=(%0d,%0d) md=%0d got=%0d/%0d/%0d lat=%0d exp=%0d/%0d/%0d lat=9",
                         it, px, py, md, h, i, c, lat, eh, ei, ec); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_cluster;
        test_boundary;
        test_hold;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
